// File: rtl/wb_timer.sv
// wb_timer: Wishbone-attached down-counting timer with level interrupt.
// Registers (adr_i[3:2]): 0 CTRL {PRESCALE[15:8], OS, IE, EN}, 1 RELOAD,
// 2 COUNT, 3 STATUS {PEND}. Optional prescaler enabled by defining
// WB_TIMER_PRESCALE_EN; without it every clock is a tick.
module wb_timer #(
  parameter logic [31:0] DEFAULT_RELOAD = 32'd50
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  input  logic [3:0]  sel_i,
  input  logic [2:0]  cti_i,
  input  logic [1:0]  bte_i,
  output logic        ack_o,
  output logic        irq_o
);

  logic        en, ie, os, pend;
  logic [31:0] reload, count;
  logic [31:0] rdata;
  logic [7:0]  prescale_rd;
  logic        tick;

  // Burst type and undecoded address bits carry no meaning for this slave.
  logic unused_bits;
  assign unused_bits = ^{cti_i, bte_i, adr_i[31:4], adr_i[1:0]};

  // A new access is accepted on any edge where ack is low; ack then pulses
  // for one cycle, so a held strobe gets acked every other cycle.
  logic acc, wr, wr_ctrl, wr_rel, wr_cnt, wr_stat;
  assign acc     = cyc_i & stb_i & ~ack_o;
  assign wr      = acc & we_i;
  assign wr_ctrl = wr & (adr_i[3:2] == 2'd0);
  assign wr_rel  = wr & (adr_i[3:2] == 2'd1);
  assign wr_cnt  = wr & (adr_i[3:2] == 2'd2);
  assign wr_stat = wr & (adr_i[3:2] == 2'd3);

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

`ifdef WB_TIMER_PRESCALE_EN
  logic [7:0] prescale, psc_cnt;
  assign tick        = (psc_cnt == prescale);
  assign prescale_rd = prescale;

  // Prescale divider: counts 0..PRESCALE, restarts on CTRL/COUNT writes so
  // software gets a full first period after reprogramming.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prescale <= 8'h0;
      psc_cnt  <= 8'h0;
    end else begin
      if (wr_ctrl && sel_i[1]) prescale <= dat_i[15:8];
      if (wr_ctrl || wr_cnt || tick) psc_cnt <= 8'h0;
      else                           psc_cnt <= psc_cnt + 8'd1;
    end
  end
`else
  assign tick        = 1'b1;
  assign prescale_rd = 8'h0;
`endif

  // Read mux for the addressed register.
  always_comb begin
    rdata = 32'h0;
    case (adr_i[3:2])
      2'd0: rdata = {16'h0, prescale_rd, 5'h0, os, ie, en};
      2'd1: rdata = reload;
      2'd2: rdata = count;
      2'd3: rdata = {31'h0, pend};
      default: rdata = 32'h0;
    endcase
  end

  logic term;
  assign term = tick & en & (count == 32'h0);

  // Bus handshake, register writes and the counter itself.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_o  <= 1'b0;
      dat_o  <= 32'h0;
      en     <= 1'b0;
      ie     <= 1'b0;
      os     <= 1'b0;
      pend   <= 1'b0;
      reload <= DEFAULT_RELOAD;
      count  <= DEFAULT_RELOAD;
    end else begin
      ack_o <= acc;
      dat_o <= acc ? rdata : 32'h0;

      // Terminal event wins over a simultaneous software clear.
      if (term)                                pend <= 1'b1;
      else if (wr_stat && sel_i[0] && dat_i[0]) pend <= 1'b0;

      if (term && os) en <= 1'b0;
      if (wr_ctrl && sel_i[0]) begin
        en <= dat_i[0];
        ie <= dat_i[1];
        os <= dat_i[2];
      end

      if (wr_rel) reload <= merge(reload, dat_i, sel_i);

      // Software COUNT write overrides the decrement/reload of this cycle.
      if (wr_cnt)                   count <= merge(count, dat_i, sel_i);
      else if (tick && en) begin
        if (count != 32'h0)         count <= count - 32'd1;
        else if (!os)               count <= reload;
      end
    end
  end

  assign irq_o = pend & ie;

endmodule

// File: doc/wb_timer.md
WB_TIMER -- requirements
Module: wb_timer

Interface
REQ-001 SHALL have parameter DEFAULT_RELOAD, default 50, reset value of RELOAD and COUNT.
REQ-002 SHALL have port clk_i  input  1  bus and counter clock; all state on rising edge.
REQ-003 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-004 SHALL have port adr_i  input  32  byte address; only [3:2] decoded.
REQ-005 SHALL have port dat_i  input  32  write data from initiator.
REQ-006 SHALL have port dat_o  output  32  read data to initiator.
REQ-007 SHALL have ports we_i, stb_i, cyc_i  input  1 each  Wishbone write enable, strobe, cycle.
REQ-008 SHALL have port sel_i  input  4  byte-lane selects; sel_i[n] qualifies dat_i[8n+7:8n].
REQ-009 SHALL have ports cti_i (3) and bte_i (2)  input  accepted and ignored.
REQ-010 SHALL have port ack_o  output  1  Wishbone acknowledge.
REQ-011 SHALL have port irq_o  output  1  level interrupt request to cpu interrupt_request_i.

Function
REQ-012 SHALL decode registers by adr_i[3:2]: 0 CTRL, 1 RELOAD, 2 COUNT, 3 STATUS.
REQ-013 CTRL SHALL hold bit0 EN (count enable), bit1 IE (interrupt enable), bit2 OS (one-shot); bits 31:3 read 0.
REQ-014 STATUS SHALL hold bit0 PEND; writing 1 to bit0 with sel_i[0] clears PEND, writing 0 has no effect.
REQ-015 ack_o SHALL be registered: next ack_o = cyc_i & stb_i & ~ack_o, giving one ack per two cycles of a held strobe, including during bursts.
REQ-016 A write SHALL commit on the same clock edge that sets ack_o, honoring sel_i per byte.
REQ-017 dat_o SHALL be registered with the addressed register on the edge that sets ack_o, and 0 on every other cycle.
REQ-018 On each tick with EN=1: COUNT!=0 -> COUNT decrements by 1; COUNT==0 -> PEND set and COUNT loaded from RELOAD (period RELOAD+1 ticks).
REQ-019 If OS=1 at terminal count, COUNT SHALL remain 0, EN SHALL clear, and PEND SHALL set.
REQ-020 With EN=0, COUNT SHALL hold.
REQ-021 A bus write to COUNT SHALL take priority over the decrement/reload in the same cycle.
REQ-022 A PEND set from terminal count and a PEND clear in the same cycle SHALL leave PEND=1.
REQ-023 RELOAD=0 SHALL produce a terminal event every tick.
REQ-024 irq_o SHALL equal PEND & IE, decoded from flops only, with no combinational path from bus inputs.
REQ-025 A bus cycle dropped (cyc_i=0) before ack SHALL commit nothing and ack_o SHALL fall on the next edge.

Reset
REQ-026 On rst_ni low, immediately and without a clock: CTRL=0, RELOAD=DEFAULT_RELOAD, COUNT=DEFAULT_RELOAD, PEND=0, ack_o=0, dat_o=0, irq_o=0, PRESCALE=0 and prescale counter=0.
REQ-027 Reset asserted mid-transfer SHALL abort the transfer; state SHALL be the reset values and no ack SHALL be issued.
REQ-028 rst_ni release SHALL be followed by normal operation on the first rising edge.

Configuration
REQ-029 With WB_TIMER_PRESCALE_EN defined, CTRL[15:8] SHALL be PRESCALE, an 8-bit prescale counter SHALL count 0..PRESCALE, a tick SHALL occur when it wraps, and it SHALL clear on any write to CTRL or COUNT.
REQ-030 Without WB_TIMER_PRESCALE_EN, every clock SHALL be a tick, CTRL[15:8] SHALL read 0, and writes to it SHALL be ignored.

Verification
REQ-031 Reset, read all four registers -> 0x0, 0x32, 0x32, 0x0; each read ack high exactly 1 cycle, 1 cycle after stb.
REQ-032 Write RELOAD=3, COUNT=3, CTRL=0x3 (no prescale) -> PEND and irq_o rise every 4 clocks; write STATUS=1 -> irq_o low next cycle.
REQ-033 CTRL=0x7, COUNT=2 -> one event after 3 ticks; EN reads 0; COUNT reads 0 thereafter; no further events.
REQ-034 COUNT write lands on the terminal-count cycle -> COUNT equals the written value with no reload; STATUS clear on the event cycle -> PEND reads 1.
REQ-035 Write 0xFFFFFFFF to RELOAD with sel_i=0x2 -> RELOAD reads 0x0000FF32; rst_ni pulsed low mid-write -> ack_o never asserts and RELOAD reads 0x32.
REQ-036 With WB_TIMER_PRESCALE_EN: CTRL=0x0401 with COUNT=1 -> COUNT decrements every 5 clocks.
